matrix_result_reader: RTL and testbench
=======================================

# matrix_result_reader

Sequential read-out engine for the 5x5 matrix coprocessor. It snapshots the 200-bit packed result matrix and its overflow flag from the multiplier on a start pulse. It then streams the elements one per transfer over a valid/ready interface toward the host bus bridge, signalling the last element and completion.

## Interface
Parameters:
- ELEM_W, 8: width of one signed matrix element.
- DIM, 5: matrix dimension. Packed matrix width is DIM*DIM*ELEM_W = 200.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to capture and stream a result; ignored while busy.
- result_in  input  200  packed result matrix; element (r,c) at bits [(r*DIM+c)*ELEM_W +: ELEM_W].
- overflow_in  input  1  overflow flag accompanying result_in.
- out_data  output  8  current element, raw two's-complement byte.
- out_index  output  5  flat index r*DIM+c of out_data.
- out_valid  output  1  out_data/out_index/out_last are valid.
- out_ready  input  1  consumer accepts; a transfer occurs on an edge where out_valid && out_ready.
- out_last  output  1  high with the final element of the stream.
- busy  output  1  high from the capture edge until the done cycle (inclusive).
- done  output  1  one-cycle pulse after the last transfer.
- overflow_out  output  1  captured overflow flag; held until the next capture.
- matrix_size  input  3  active dimension, sampled at start; present only with RESULT_SIZE_TRIM_EN.

## Operation
- States: IDLE, SEND, DONE.
- IDLE: out_valid=0, busy=0. If start=1 on an edge, the block does the following on that edge: latch result_in into the shadow register, latch overflow_in into overflow_out, clear row/col to 0, and go to SEND.
- SEND: out_valid=1 and out_data=shadow[(row*DIM+col)*8 +: 8], with out_index=row*DIM+col. Each transfer advances col; when col wraps past the last column, col returns to 0 and row increments. Order is row-major.
- out_last=1 when row and col are both at the final active position. A transfer with out_last=1 moves the block to DONE.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE. out_valid=0 in DONE.
- start during SEND or DONE is ignored. The shadow register and overflow_out do not change.
- The shadow register isolates the stream from changes on result_in after capture.
- No arithmetic is performed on data. Elements pass through bit-exact.

## Timing
- Reset (rst_n=0, asynchronous): state IDLE; out_data=0, out_index=0, out_valid=0, out_last=0, busy=0, done=0, overflow_out=0; shadow register cleared. Reset mid-stream abandons the stream immediately, with no done pulse.
- Latency: start sampled at edge T, so out_valid=1 with element 0 from cycle T+1.
- With out_ready held at 1, there is one element per cycle. Full 25-element stream: valid during cycles T+1..T+25, done at T+26, IDLE (busy=0) at T+27.
- Back-pressure: while out_valid && !out_ready, out_data, out_index and out_last hold stable. out_valid never deasserts before its transfer.
- out_ready is don't-care when out_valid=0.
- A start arriving in the same cycle as done is ignored. A start in the first IDLE cycle after done is accepted.

## Configuration
- RESULT_SIZE_TRIM_EN defined: the matrix_size port exists and is sampled at capture. The active dimension N is set as follows: 0 or 1 gives N=2; 2..5 gives N=matrix_size; 6 or 7 gives N=5. Only elements with row<N and col<N are streamed (N*N transfers). out_index still reports the flat position r*5+c, and out_last marks element (N-1,N-1).
- RESULT_SIZE_TRIM_EN undefined: no matrix_size port; N is fixed at DIM, and all 25 elements are always streamed.

## Test plan
- Load result_in with element k = k+1 and overflow_in=1; pulse start with out_ready=1. Expect out_data 1..25 on cycles T+1..T+25, out_index 0..24, out_last only at index 24, done at T+26, and overflow_out=1.
- Toggle out_ready 1,0,0,1 throughout the stream. Expect data to hold during stalls, no element dropped or duplicated, and exactly 25 transfers.
- Change result_in to all 0xFF right after capture. Expect the streamed values to be unchanged. Pulse start mid-stream and expect no restart.
- Assert rst_n=0 at element 10. Expect all outputs 0 asynchronously, no done pulse, and a clean new stream after the next start.
- With RESULT_SIZE_TRIM_EN and matrix_size=3, expect 9 transfers with out_index 0,1,2,5,6,7,10,11,12 and out_last at 12. With matrix_size=7, expect 25 transfers.
- Element value 0x80 (-128) streams as out_data=0x80.

Source files
------------

// File: rtl/matrix_result_reader.sv
// Streams a captured DIM x DIM result matrix one element per valid/ready transfer.
// Optional `RESULT_SIZE_TRIM_EN adds matrix_size to stream only the top-left N x N block.
module matrix_result_reader #(
  parameter int ELEM_W = 8,
  parameter int DIM    = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [DIM*DIM*ELEM_W-1:0]     result_in,
  input  logic                          overflow_in,
  output logic [ELEM_W-1:0]             out_data,
  output logic [$clog2(DIM*DIM)-1:0]    out_index,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic                          busy,
  output logic                          done,
  output logic                          overflow_out
`ifdef RESULT_SIZE_TRIM_EN
  ,
  input  logic [2:0]                    matrix_size
`endif
);

  localparam int RC_W  = $clog2(DIM);
  localparam int IDX_W = $clog2(DIM*DIM);
  localparam int NEL   = DIM*DIM;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_e;

  state_e                    state_q, state_d;
  logic [NEL*ELEM_W-1:0]     shadow_q, shadow_d;
  logic                      ovf_q, ovf_d;
  logic [RC_W-1:0]           row_q, row_d;
  logic [RC_W-1:0]           col_q, col_d;
  logic [RC_W-1:0]           last_pos;
  logic [IDX_W-1:0]          cur_idx;
  logic                      at_last;
  logic [ELEM_W-1:0]         elem [NEL];

`ifdef RESULT_SIZE_TRIM_EN
  logic [RC_W-1:0]           last_q, last_d;

  // Sizes below 2 round up to 2, sizes above DIM clamp to DIM; store N-1.
  function automatic logic [RC_W-1:0] last_from_size(input logic [2:0] sz);
    if (sz < 3'd2)         return RC_W'(1);
    else if (int'(sz) > DIM) return RC_W'(DIM - 1);
    else                   return RC_W'(sz - 3'd1);
  endfunction

  assign last_pos = last_q;
`else
  assign last_pos = RC_W'(DIM - 1);
`endif

  for (genvar k = 0; k < NEL; k++) begin : g_elem
    assign elem[k] = shadow_q[k*ELEM_W +: ELEM_W];
  end

  assign cur_idx = IDX_W'(row_q) * IDX_W'(DIM) + IDX_W'(col_q);
  assign at_last = (row_q == last_pos) && (col_q == last_pos);

  // NOTE: every next-state variable gets its hold value first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    ovf_d    = ovf_q;
    row_d    = row_q;
    col_d    = col_q;
`ifdef RESULT_SIZE_TRIM_EN
    last_d   = last_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          shadow_d = result_in;
          ovf_d    = overflow_in;
          row_d    = '0;
          col_d    = '0;
`ifdef RESULT_SIZE_TRIM_EN
          last_d   = last_from_size(matrix_size);
`endif
          state_d  = S_SEND;
        end
      end
      S_SEND: begin
        if (out_ready) begin
          if (at_last) begin
            state_d = S_DONE;
          end else if (col_q == last_pos) begin
            col_d = '0;
            row_d = row_q + RC_W'(1);
          end else begin
            col_d = col_q + RC_W'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments; the shadow matrix is reset too, so out_data reads 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      shadow_q <= '0;
      ovf_q    <= 1'b0;
      row_q    <= '0;
      col_q    <= '0;
`ifdef RESULT_SIZE_TRIM_EN
      last_q   <= RC_W'(DIM - 1);
`endif
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      ovf_q    <= ovf_d;
      row_q    <= row_d;
      col_q    <= col_d;
`ifdef RESULT_SIZE_TRIM_EN
      last_q   <= last_d;
`endif
    end
  end

  // Stream outputs are forced to zero outside SEND so idle and reset values read clean.
  assign out_valid    = (state_q == S_SEND);
  assign out_data     = out_valid ? elem[cur_idx] : '0;
  assign out_index    = out_valid ? cur_idx : '0;
  assign out_last     = out_valid && at_last;
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign overflow_out = ovf_q;

endmodule

// File: tb/tb_matrix_result_reader.sv
// Scoreboard bench for matrix_result_reader: expected elements are queued at start
// and popped on each observed transfer.
`timescale 1ns/1ps
module tb_matrix_result_reader;

  localparam int NEL = 25;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [199:0] result_in;
  logic         overflow_in;
  logic [7:0]   out_data;
  logic [4:0]   out_index;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic         busy;
  logic         done;
  logic         overflow_out;
`ifdef RESULT_SIZE_TRIM_EN
  logic [2:0]   matrix_size;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic [4:0] index;
    logic       last;
  } xfer_t;

  xfer_t      exp_q[$];
  int         errors = 0;
  int         checks = 0;
  logic [7:0] elem [NEL];

  matrix_result_reader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .result_in    (result_in),
    .overflow_in  (overflow_in),
    .out_data     (out_data),
    .out_index    (out_index),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .busy         (busy),
    .done         (done),
    .overflow_out (overflow_out)
`ifdef RESULT_SIZE_TRIM_EN
    ,
    .matrix_size  (matrix_size)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [199:0] pack_elems();
    logic [199:0] v;
    for (int k = 0; k < NEL; k++) v[k*8 +: 8] = elem[k];
    return v;
  endfunction

  task automatic push_expected(input int n);
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++)
        exp_q.push_back({elem[r*5+c], 5'(r*5+c), 1'((r == n-1) && (c == n-1))});
  endtask

  // Called just after a falling edge; the capture edge is the next rising edge.
  task automatic load_and_start(input logic ovf, input int n);
    result_in   = pack_elems();
    overflow_in = ovf;
    start       = 1'b1;
    push_expected(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Consumes the stream, comparing every transfer against the scoreboard.
  task automatic drain(input bit stall_mode, input int start_at, input int abort_at,
                       output int n_xfer, output int n_cyc);
    xfer_t got, want, held;
    bit    stalled, pulsed, fin;
    stalled = 0; pulsed = 0; fin = 0;
    held = '0;
    n_xfer = 0; n_cyc = 0;
    while (!fin) begin
      if (n_cyc >= 200) begin
        checks++; errors++;
        $display("FAIL drain_timeout: got %0d transfers in %0d cycles, want stream end", n_xfer, n_cyc);
        fin = 1;
      end else if (abort_at >= 0 && n_xfer == abort_at) begin
        fin = 1;
      end else begin
        out_ready = stall_mode ? ((n_cyc % 4 == 0) || (n_cyc % 4 == 3)) : 1'b1;
        if (start_at >= 0 && n_xfer == start_at && !pulsed) begin
          start = 1'b1;
          overflow_in = ~overflow_in;
          pulsed = 1;
        end
        got = {out_data, out_index, out_last};
        if (stalled) begin
          checks++;
          if (!out_valid || got !== held) begin
            errors++;
            $display("FAIL stall_hold: got valid=%b %h, want valid=1 %h", out_valid, got, held);
          end
        end
        if (out_valid) begin
          stalled = !out_ready;
          held    = got;
          if (out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL extra_xfer: got data=%h idx=%0d last=%b, want no transfer",
                       out_data, out_index, out_last);
            end else begin
              want = exp_q.pop_front();
              if (got !== want) begin
                errors++;
                $display("FAIL xfer_%0d: got data=%h idx=%0d last=%b, want data=%h idx=%0d last=%b",
                         n_xfer, got.data, got.index, got.last, want.data, want.index, want.last);
              end
            end
            n_xfer++;
            if (out_last) fin = 1;
          end
        end else begin
          stalled = 0;
        end
        n_cyc++;
        @(negedge clk);
        start = 1'b0;
      end
    end
  endtask

  // Expects to be at the done cycle; checks it and the following idle cycle.
  task automatic check_done_then_idle(input string tag);
    checks++;
    if (done !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_done: got done=%b busy=%b valid=%b, want 1 1 0", tag, done, busy, out_valid);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: got done=%b busy=%b, want 0 0", tag, done, busy);
    end
  endtask

  task automatic check_count(input string tag, input int got_n, input int want_n);
    checks++;
    if (got_n !== want_n || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_count: got %0d (left %0d), want %0d (left 0)", tag, got_n, exp_q.size(), want_n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0; overflow_in = 1'b0; result_in = '0;
`ifdef RESULT_SIZE_TRIM_EN
    matrix_size = 3'd5;
`endif
    repeat (3) @(negedge clk);
    checks++;
    if ({out_data, out_index, out_valid, out_last, busy, done, overflow_out} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got data=%h idx=%0d v=%b l=%b b=%b d=%b o=%b, want all 0",
               out_data, out_index, out_valid, out_last, busy, done, overflow_out);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got busy=%b valid=%b, want 0 0", busy, out_valid);
    end
  endtask

  task automatic test_full_stream();
    int nx, nc;
    for (int k = 0; k < NEL; k++) elem[k] = 8'(k + 1);
    load_and_start(1'b1, 5);
    drain(0, -1, -1, nx, nc);
    check_count("full", nx, 25);
    checks++;
    if (nc !== 25 || overflow_out !== 1'b1) begin
      errors++;
      $display("FAIL full_timing: got cycles=%0d ovf=%b, want 25 1", nc, overflow_out);
    end
    check_done_then_idle("full");
  endtask

  task automatic test_backpressure();
    int nx, nc;
    for (int k = 0; k < NEL; k++) elem[k] = 8'($urandom);
    load_and_start(1'b0, 5);
    drain(1, -1, -1, nx, nc);
    check_count("bp", nx, 25);
    checks++;
    if (overflow_out !== 1'b0) begin
      errors++;
      $display("FAIL bp_ovf: got %b, want 0", overflow_out);
    end
    check_done_then_idle("bp");
  endtask

  task automatic test_isolation();
    int nx, nc;
    for (int k = 0; k < NEL; k++) elem[k] = 8'($urandom_range(0, 254));
    elem[0] = 8'h80; elem[24] = 8'h80;
    load_and_start(1'b0, 5);
    result_in = '1;
    drain(0, 5, -1, nx, nc);
    check_count("iso", nx, 25);
    checks++;
    if (nc !== 25 || overflow_out !== 1'b0) begin
      errors++;
      $display("FAIL iso_restart: got cycles=%0d ovf=%b, want 25 0", nc, overflow_out);
    end
    check_done_then_idle("iso");
    overflow_in = 1'b0;
  endtask

  task automatic test_signed();
    int nx, nc;
    for (int k = 0; k < NEL; k++) elem[k] = (k % 2 == 0) ? 8'h80 : 8'h7F;
    load_and_start(1'b0, 5);
    drain(1, -1, -1, nx, nc);
    check_count("signed", nx, 25);
    check_done_then_idle("signed");
  endtask

  task automatic test_reset_midstream();
    int nx, nc;
    for (int k = 0; k < NEL; k++) elem[k] = 8'($urandom);
    load_and_start(1'b1, 5);
    drain(0, -1, 10, nx, nc);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_data, out_index, out_valid, out_last, busy, done, overflow_out} !== '0) begin
      errors++;
      $display("FAIL midreset_async: got data=%h idx=%0d v=%b l=%b b=%b d=%b o=%b, want all 0",
               out_data, out_index, out_valid, out_last, busy, done, overflow_out);
    end
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL midreset_nodone: got done=%b busy=%b, want 0 0", done, busy);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < NEL; k++) elem[k] = 8'(8'hC0 + k);
    load_and_start(1'b0, 5);
    drain(0, -1, -1, nx, nc);
    check_count("midreset_restream", nx, 25);
    check_done_then_idle("midreset");
  endtask

  task automatic test_start_on_done();
    int nx, nc;
    for (int k = 0; k < NEL; k++) elem[k] = 8'(8'h40 + k);
    load_and_start(1'b0, 5);
    drain(0, -1, -1, nx, nc);
    check_count("sod_first", nx, 25);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL sod_done: got done=%b, want 1", done);
    end
    for (int k = 0; k < NEL; k++) elem[k] = 8'(8'hA0 - k);
    result_in = pack_elems();
    start = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL sod_ignored: got busy=%b valid=%b, want 0 0", busy, out_valid);
    end
    push_expected(5);
    @(negedge clk);
    start = 1'b0;
    drain(0, -1, -1, nx, nc);
    check_count("sod_second", nx, 25);
    check_done_then_idle("sod");
  endtask

`ifdef RESULT_SIZE_TRIM_EN
  function automatic int size_to_n(input logic [2:0] sz);
    if (sz <= 3'd1) return 2;
    if (sz >= 3'd6) return 5;
    return int'(sz);
  endfunction

  task automatic test_trim();
    int nx, nc;
    logic [2:0] sizes [3];
    sizes[0] = 3'd3; sizes[1] = 3'd7; sizes[2] = 3'd1;
    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < NEL; k++) elem[k] = 8'($urandom);
      matrix_size = sizes[s];
      load_and_start(1'b0, size_to_n(sizes[s]));
      matrix_size = 3'd5;
      drain(0, -1, -1, nx, nc);
      check_count("trim", nx, size_to_n(sizes[s]) * size_to_n(sizes[s]));
      check_done_then_idle("trim");
    end
  endtask
`endif

  initial begin
    test_reset();
    test_full_stream();
    test_backpressure();
    test_isolation();
    test_signed();
    test_reset_midstream();
    test_start_on_done();
`ifdef RESULT_SIZE_TRIM_EN
    test_trim();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
